// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, write-back source codes and FSM encoding for the MEM/WB boundary.
package mem_wb_stage_pkg;

  localparam int unsigned DEFAULT_IO_BUS_SIZE   = 32;
  localparam int unsigned DEFAULT_REG_ADDR_SIZE = 5;
  localparam int unsigned DEFAULT_COUNT_SIZE    = 32;

  // Write-back source select codes; 2'b11 is reserved and yields a zero word.
  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_RET  = 2'b10;
  localparam logic [1:0] WB_SRC_RSVD = 2'b11;

  // Number of real sources feeding the generic mux.
  localparam int unsigned WB_CHANNELS = 3;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the memory stage / register file and the MEM/WB register.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned IO_BUS_SIZE   = DEFAULT_IO_BUS_SIZE,
  parameter int unsigned REG_ADDR_SIZE = DEFAULT_REG_ADDR_SIZE,
  parameter int unsigned COUNT_SIZE    = DEFAULT_COUNT_SIZE
);

  // Memory-stage side
  logic                     i_enable;
  logic                     i_flush;
  logic                     i_valid;
  logic                     i_halt;
  logic                     i_reg_wr;
  logic [1:0]               i_wb_src;
  logic [REG_ADDR_SIZE-1:0] i_wr_reg_addr;
  logic [IO_BUS_SIZE-1:0]   i_mem_rd;
  logic [IO_BUS_SIZE-1:0]   i_alu_result;
  logic [IO_BUS_SIZE-1:0]   i_return_addr;

  // Register-file / debug side
  logic                     o_reg_wr;
  logic [REG_ADDR_SIZE-1:0] o_wr_reg_addr;
  logic [IO_BUS_SIZE-1:0]   o_wb_data;
  logic                     o_valid;
  logic                     o_halt;
  logic [COUNT_SIZE-1:0]    o_retired;

  modport master (
    output i_enable, i_flush, i_valid, i_halt, i_reg_wr, i_wb_src, i_wr_reg_addr,
    output i_mem_rd, i_alu_result, i_return_addr,
    input  o_reg_wr, o_wr_reg_addr, o_wb_data, o_valid, o_halt, o_retired
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_halt, i_reg_wr, i_wb_src, i_wr_reg_addr,
    input  i_mem_rd, i_alu_result, i_return_addr,
    output o_reg_wr, o_wr_reg_addr, o_wb_data, o_valid, o_halt, o_retired
  );

endinterface

// File: rtl/mem_wb_stage_mux.sv
// Generic N-channel one-of-N word selector; selects outside 0..CHANNELS-1 give zero.
module mem_wb_stage_mux #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned BUS_SIZE = 32,
  localparam int unsigned SelSize = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [SelSize-1:0]           i_sel,
  input  logic [CHANNELS*BUS_SIZE-1:0] i_data,
  output logic [BUS_SIZE-1:0]          o_data
);

  // Channel ch lives at bits [ch*BUS_SIZE +: BUS_SIZE] of the flattened input.
  always_comb begin
    o_data = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (i_sel == SelSize'(ch)) begin
        o_data = i_data[ch*BUS_SIZE +: BUS_SIZE];
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures memory-stage results, selects the write-back word,
// qualifies the register-file strobe and tracks halt and retired-instruction count.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned IO_BUS_SIZE   = DEFAULT_IO_BUS_SIZE,
  parameter int unsigned REG_ADDR_SIZE = DEFAULT_REG_ADDR_SIZE,
  parameter int unsigned COUNT_SIZE    = DEFAULT_COUNT_SIZE
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_wb_stage_if.slave bus
);

  state_e                   state_q;
  logic                     valid_q;
  logic                     halt_q;
  logic                     reg_wr_q;
  logic [1:0]               wb_src_q;
  logic [REG_ADDR_SIZE-1:0] wr_reg_addr_q;
  logic [IO_BUS_SIZE-1:0]   mem_rd_q;
  logic [IO_BUS_SIZE-1:0]   alu_result_q;
  logic [IO_BUS_SIZE-1:0]   return_addr_q;
  logic [COUNT_SIZE-1:0]    retired_q;
  logic [IO_BUS_SIZE-1:0]   mux_data;

  // Pipeline register and RUN/HALTED FSM; HALTED freezes everything until reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= StRun;
      valid_q       <= 1'b0;
      halt_q        <= 1'b0;
      reg_wr_q      <= 1'b0;
      wb_src_q      <= WB_SRC_ALU;
      wr_reg_addr_q <= '0;
      mem_rd_q      <= '0;
      alu_result_q  <= '0;
      return_addr_q <= '0;
      retired_q     <= '0;
    end else if (state_q == StRun && bus.i_enable) begin
      if (bus.i_flush) begin
        valid_q       <= 1'b0;
        halt_q        <= 1'b0;
        reg_wr_q      <= 1'b0;
        wb_src_q      <= WB_SRC_ALU;
        wr_reg_addr_q <= '0;
        mem_rd_q      <= '0;
        alu_result_q  <= '0;
        return_addr_q <= '0;
      end else begin
        valid_q       <= bus.i_valid;
        // A halt on a bubble slot is meaningless, so only a real HALT is remembered.
        halt_q        <= bus.i_valid & bus.i_halt;
        reg_wr_q      <= bus.i_reg_wr;
        wb_src_q      <= bus.i_wb_src;
        wr_reg_addr_q <= bus.i_wr_reg_addr;
        mem_rd_q      <= bus.i_mem_rd;
        alu_result_q  <= bus.i_alu_result;
        return_addr_q <= bus.i_return_addr;
        if (bus.i_valid) begin
          retired_q <= retired_q + COUNT_SIZE'(1);
          if (bus.i_halt) begin
            state_q <= StHalted;
          end
        end
      end
    end
  end

  mem_wb_stage_mux #(
    .CHANNELS(WB_CHANNELS),
    .BUS_SIZE(IO_BUS_SIZE)
  ) u_wb_mux (
    .i_sel (wb_src_q),
    .i_data({return_addr_q, mem_rd_q, alu_result_q}),
    .o_data(mux_data)
  );

  // Output decode: reserved source reads as zero; strobe never fires for $zero,
  // bubbles, or the HALT instruction itself.
  always_comb begin
    bus.o_wb_data     = (wb_src_q == WB_SRC_RSVD) ? '0 : mux_data;
    bus.o_reg_wr      = reg_wr_q & valid_q & (wr_reg_addr_q != '0) & ~halt_q;
    bus.o_wr_reg_addr = wr_reg_addr_q;
    bus.o_valid       = valid_q;
    bus.o_halt        = (state_q == StHalted);
    bus.o_retired     = retired_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares one cycle later.
module tb_mem_wb_stage;

  logic clk;
  logic rst_n;

  mem_wb_stage_if #(.IO_BUS_SIZE(32), .REG_ADDR_SIZE(5), .COUNT_SIZE(32)) m ();
  mem_wb_stage_if #(.IO_BUS_SIZE(32), .REG_ADDR_SIZE(5), .COUNT_SIZE(4))  w ();

  mem_wb_stage #(.IO_BUS_SIZE(32), .REG_ADDR_SIZE(5), .COUNT_SIZE(32)) u_dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (m)
  );

  mem_wb_stage #(.IO_BUS_SIZE(32), .REG_ADDR_SIZE(5), .COUNT_SIZE(4)) u_wrap (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (w)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  a;
    logic [31:0] d;
    logic        v;
    logic        h;
    logic [31:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string nm, input logic rw, input logic [4:0] a,
                           input logic [31:0] d, input logic v, input logic h,
                           input logic [31:0] r);
    n_vec++;
    if ({m.o_reg_wr, m.o_wr_reg_addr, m.o_wb_data, m.o_valid, m.o_halt, m.o_retired} !==
        {rw, a, d, v, h, r}) begin
      n_err++;
      $display("FAIL %s: got reg_wr=%0b addr=%0d data=%h valid=%0b halt=%0b retired=%0d ; want reg_wr=%0b addr=%0d data=%h valid=%0b halt=%0b retired=%0d",
               nm, m.o_reg_wr, m.o_wr_reg_addr, m.o_wb_data, m.o_valid, m.o_halt,
               m.o_retired, rw, a, d, v, h, r);
    end
  endtask

  // Monitor: every expectation was pushed before the edge that captures it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out(e.name, e.rw, e.a, e.d, e.v, e.h, e.r);
      end
    end
  end

  task automatic drive(input logic en, input logic fl, input logic v, input logic h,
                       input logic rw, input logic [1:0] src, input logic [4:0] addr,
                       input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] ret);
    m.i_enable      = en;
    m.i_flush       = fl;
    m.i_valid       = v;
    m.i_halt        = h;
    m.i_reg_wr      = rw;
    m.i_wb_src      = src;
    m.i_wr_reg_addr = addr;
    m.i_mem_rd      = mem;
    m.i_alu_result  = alu;
    m.i_return_addr = ret;
  endtask

  task automatic vec(input string nm, input logic en, input logic fl, input logic v,
                     input logic h, input logic rw, input logic [1:0] src,
                     input logic [4:0] addr, input logic [31:0] mem, input logic [31:0] alu,
                     input logic [31:0] ret, input logic e_rw, input logic [4:0] e_a,
                     input logic [31:0] e_d, input logic e_v, input logic e_h,
                     input logic [31:0] e_r);
    exp_t e;
    drive(en, fl, v, h, rw, src, addr, mem, alu, ret);
    e.name = nm; e.rw = e_rw; e.a = e_a; e.d = e_d; e.v = e_v; e.h = e_h; e.r = e_r;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    w.i_enable = 1'b0; w.i_flush = 1'b0; w.i_valid = 1'b0; w.i_halt = 1'b0;
    w.i_reg_wr = 1'b0; w.i_wb_src = 2'b00; w.i_wr_reg_addr = 5'd0;
    w.i_mem_rd = 32'h0; w.i_alu_result = 32'h0; w.i_return_addr = 32'h0;
    #12;
    check_out("reset_state", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;

    //  name          en fl v  h  rw src    addr   mem            alu           ret
    vec("load_sel",   1, 0, 1, 0, 1, 2'b01, 5'd5,  32'hFFFFFF80, 32'h10,       32'h0,
        1, 5'd5, 32'hFFFFFF80, 1, 0, 32'd1);
    vec("ret_sel",    1, 0, 1, 0, 1, 2'b10, 5'd6,  32'h1,        32'h2,        32'h24,
        1, 5'd6, 32'h24, 1, 0, 32'd2);
    vec("zero_guard", 1, 0, 1, 0, 1, 2'b00, 5'd0,  32'h0,        32'h1234,     32'h0,
        0, 5'd0, 32'h1234, 1, 0, 32'd3);
    vec("invalid",    1, 0, 0, 0, 1, 2'b00, 5'd3,  32'h0,        32'h55,       32'h0,
        0, 5'd3, 32'h55, 0, 0, 32'd3);
    vec("rsvd_src",   1, 0, 1, 0, 1, 2'b11, 5'd9,  32'h11,       32'h77,       32'h22,
        1, 5'd9, 32'h0, 1, 0, 32'd4);
    vec("cap_addr7",  1, 0, 1, 0, 1, 2'b00, 5'd7,  32'h0,        32'hAA,       32'h0,
        1, 5'd7, 32'hAA, 1, 0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      vec("stall_hold", 0, 1, 1, 0, 1, 2'b01, 5'd12, 32'h99,     32'h99,       32'h99,
          1, 5'd7, 32'hAA, 1, 0, 32'd5);
    end
    vec("flush",      1, 1, 1, 0, 1, 2'b01, 5'd12, 32'h99,       32'h99,       32'h99,
        0, 5'd0, 32'h0, 0, 0, 32'd5);
    vec("no_reg_wr",  1, 0, 1, 0, 0, 2'b01, 5'd4,  32'hDEAD,     32'h1,        32'h0,
        0, 5'd4, 32'hDEAD, 1, 0, 32'd6);
    vec("halt_inval", 1, 0, 0, 1, 1, 2'b00, 5'd8,  32'h0,        32'h1,        32'h0,
        0, 5'd8, 32'h1, 0, 0, 32'd6);
    vec("halt_enter", 1, 0, 1, 1, 1, 2'b00, 5'd2,  32'h0,        32'h33,       32'h0,
        0, 5'd2, 32'h33, 1, 1, 32'd7);
    vec("halt_frz_c", 1, 0, 1, 0, 1, 2'b00, 5'd11, 32'h0,        32'h5,        32'h0,
        0, 5'd2, 32'h33, 1, 1, 32'd7);
    vec("halt_frz_f", 1, 1, 1, 0, 1, 2'b00, 5'd11, 32'h0,        32'h5,        32'h0,
        0, 5'd2, 32'h33, 1, 1, 32'd7);
    vec("halt_frz_s", 0, 0, 1, 0, 1, 2'b00, 5'd11, 32'h0,        32'h5,        32'h0,
        0, 5'd2, 32'h33, 1, 1, 32'd7);

    // Asynchronous reset mid-cycle clears halt without a clock edge.
    #3 rst_n = 1'b0;
    #1 check_out("reset_halt", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      vec("refill", 1, 0, 1, 0, 1, 2'b00, 5'(i + 1), 32'h0, 32'(i * 3), 32'h0,
          1, 5'(i + 1), 32'(i * 3), 1, 0, 32'(i + 1));
    end

    // Retired=7 and reg_wr=1 here; reset must clear all outputs before the next edge.
    #3 rst_n = 1'b0;
    #1 check_out("reset_async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'd0);
    #1 rst_n = 1'b1;
    vec("post_reset", 1, 0, 1, 0, 1, 2'b00, 5'd1, 32'h0, 32'h42, 32'h0,
        1, 5'd1, 32'h42, 1, 0, 32'd1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    // Counter wrap on the 4-bit counter build: 15 then 0.
    w.i_enable = 1'b1; w.i_valid = 1'b1; w.i_reg_wr = 1'b1; w.i_wr_reg_addr = 5'd1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #2;
      if (i == 14) begin
        n_vec++;
        if (w.o_retired !== 32'd15) begin
          n_err++;
          $display("FAIL wrap_pre: got retired=%0d, want 15", w.o_retired);
        end
      end
    end
    n_vec++;
    if (w.o_retired !== 32'd0) begin
      n_err++;
      $display("FAIL wrap: got retired=%0d, want 0", w.o_retired);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Pipeline boundary between the memory-access stage and the register-file write-back stage of the MIPS datapath. Captures the memory stage's results (load data, ALU result, return address) and write-back controls on each enabled clock. Presents the selected write-back word, destination register and write strobe to the register file. Also tracks program halt and retired-instruction count for the debug unit.

Parameters:
IO_BUS_SIZE, 32, width of data words (load data, ALU result, return address, write-back data)
REG_ADDR_SIZE, 5, width of register-file address
COUNT_SIZE, 32, width of retired-instruction counter

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous reset, active-low
i_enable  input  1  1 = advance pipeline; 0 = stall, hold all state
i_flush  input  1  1 = load a bubble instead of incoming instruction
i_valid  input  1  incoming instruction is real (not bubble)
i_halt  input  1  incoming instruction is HALT
i_reg_wr  input  1  incoming instruction writes register file
i_wb_src  input  2  write-back source: 00 ALU result, 01 load data, 10 return address, 11 reserved (drives zero)
i_wr_reg_addr  input  REG_ADDR_SIZE  destination register
i_mem_rd  input  IO_BUS_SIZE  extended load data from memory stage
i_alu_result  input  IO_BUS_SIZE  ALU result forwarded by memory stage
i_return_addr  input  IO_BUS_SIZE  link address for JAL/JALR
o_reg_wr  output  1  register-file write strobe
o_wr_reg_addr  output  REG_ADDR_SIZE  register-file write address
o_wb_data  output  IO_BUS_SIZE  register-file write data (also forwarding source)
o_valid  output  1  registered instruction is real
o_halt  output  1  HALT has reached write-back; sticky
o_retired  output  COUNT_SIZE  number of valid instructions that reached write-back

Behaviour:
- Reset (i_reset=0, asynchronous): all registered fields zero; o_reg_wr=0, o_wr_reg_addr=0, o_wb_data=0, o_valid=0, o_halt=0, o_retired=0; FSM to RUN.
- Latency: one cycle. Inputs sampled on rising edge; o_wb_data is combinational mux of registered fields selected by registered wb_src.
- FSM states: RUN, HALTED.
  - RUN, i_enable=1, i_flush=1: load bubble (valid=0, reg_wr=0, halt=0, address/data/src zero); counter unchanged.
  - RUN, i_enable=1, i_flush=0: capture all inputs; if i_valid=1 then o_retired += 1 (wraps modulo 2^COUNT_SIZE); if i_valid=1 and i_halt=1 go to HALTED.
  - RUN, i_enable=0: hold every register, including counter; i_flush ignored.
  - HALTED: o_halt=1; all registers frozen regardless of i_enable/i_flush; only reset leaves.
- Priority: reset > HALTED freeze > i_enable=0 stall > i_flush > capture.
- i_halt with i_valid=0 is ignored.
- Write-strobe qualification: o_reg_wr = registered reg_wr AND registered valid AND (wr_reg_addr != 0) AND NOT halted-instruction. The HALT instruction itself never writes.
- Flushed or invalid slot: o_reg_wr=0; o_wb_data still reflects registered fields (zero after flush).
- i_wb_src=11 captured as-is; o_wb_data=0 for that code.
- Reset mid-operation: immediate clear of every output, no clock needed; the first capture after release follows RUN rules.

Decomposition:
- Shared header: DEFAULT widths (IO_BUS_SIZE, REG_ADDR_SIZE), write-back source encodings (WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_RET=2'b10), FSM state encodings.
- One sub-module: write-back source selection reuses the existing generic mux (CHANNELS=3, BUS_SIZE=IO_BUS_SIZE) with code 11 handled in the stage. Registers and FSM stay in mem_wb_stage.

Test Plan:
- Reset: drive i_reset=0 mid-run with o_retired=7 and o_reg_wr=1 -> all outputs 0 immediately, before the next edge.
- Capture/select: valid, reg_wr=1, addr=5, wb_src=01, mem_rd=0xFFFFFF80, alu=0x10 -> next cycle o_wb_data=0xFFFFFF80, o_wr_reg_addr=5, o_reg_wr=1, o_retired=1; repeat with wb_src=10, ret=0x24 -> o_wb_data=0x24.
- $zero guard and invalid: reg_wr=1, addr=0 -> o_reg_wr=0 with o_retired incremented. i_valid=0, addr=3 -> o_reg_wr=0 with o_retired unchanged.
- Stall vs flush: capture addr=7; then i_enable=0 with i_flush=1 for 3 cycles -> outputs held at addr=7, counter held. Then i_enable=1, i_flush=1 -> o_valid=0, o_reg_wr=0, o_wb_data=0.
- Halt: valid HALT enters -> next cycle o_halt=1, o_reg_wr=0, o_retired incremented by 1. Further valid inputs with i_enable=1 -> no change; reset clears o_halt.
- Counter wrap: preload to 0xFFFFFFFF (via 2^32-1 captures or a COUNT_SIZE=4 build at 15), then one valid capture -> o_retired=0.
